id_ex_operand_stage: RTL
========================

// Module: id_ex_operand_stage
// PURPOSE
//   ID/EX pipeline register plus EX-stage operand forwarding for the RV32IM core. Captures decoded
//   fields each cycle, builds the 5-bit ALU SELECT code, resolves RAW hazards from EX/MEM and MEM/WB.
//   Drives the ALU's DATA1/DATA2/SELECT inputs directly. Store data and rd/write-enable pass on to EX/MEM.
// PARAMETERS
//   XLEN      32  datapath width
//   REG_AW    5   register address width
// PORTS
//   CLK              in   1      core clock, all state on rising edge
//   RESET            in   1      synchronous, active-high
//   STALL            in   1      hold ID/EX register contents
//   FLUSH            in   1      load a bubble into ID/EX
//   ID_VALID         in   1      ID stage holds a real instruction
//   ID_PC            in   XLEN   instruction PC
//   ID_RS1_DATA      in   XLEN   register-file read port 1
//   ID_RS2_DATA      in   XLEN   register-file read port 2
//   ID_IMM           in   XLEN   sign-extended immediate
//   ID_RS1_ADDR      in   REG_AW source register 1
//   ID_RS2_ADDR      in   REG_AW source register 2
//   ID_RD_ADDR       in   REG_AW destination register
//   ID_FUNC3         in   3      instruction func3
//   ID_FUNC7_0       in   1      func7[0] (M-extension)
//   ID_FUNC7_5       in   1      func7[5] (SUB/SRA)
//   ID_IS_RTYPE      in   1      1 = R-type (func7 bits meaningful)
//   ID_OP1_SEL       in   1      0 = rs1, 1 = PC
//   ID_OP2_SEL       in   1      0 = rs2, 1 = immediate
//   ID_REG_WRITE     in   1      instruction writes rd
//   EXMEM_RD_ADDR    in   REG_AW / EXMEM_REG_WRITE in 1 / EXMEM_RESULT in XLEN   EX/MEM forward source
//   MEMWB_RD_ADDR    in   REG_AW / MEMWB_REG_WRITE in 1 / MEMWB_RESULT in XLEN   MEM/WB forward source
//   ALU_DATA1        out  XLEN   ALU operand 1 (post-forwarding)
//   ALU_DATA2        out  XLEN   ALU operand 2 (post-forwarding)
//   ALU_SELECT       out  5      {func3, func7[0], func7[5]}
//   EX_STORE_DATA    out  XLEN   forwarded rs2 value (for stores)
//   EX_PC / EX_RD_ADDR / EX_REG_WRITE / EX_VALID  out  XLEN/REG_AW/1/1  pipelined fields
// BEHAVIOUR
//   - Reset: every register 0; EX_VALID=0, EX_REG_WRITE=0, ALU_SELECT=0, EX_PC=0, EX_RD_ADDR=0.
//   - Latency: ID fields appear on EX outputs 1 cycle after capture. Forward muxes are combinational.
//   - Priority per edge: RESET > FLUSH > STALL > load. FLUSH with STALL -> bubble.
//   - Bubble: VALID=0, REG_WRITE=0, SELECT=0, rd=0, rs addrs=0; data fields don't-care (zeroed).
//   - Load with ID_VALID=0 gives a bubble, as above.
//   - SELECT build: R-type -> {func3,func7_0,func7_5}. Non-R-type -> func7_0 forced 0.
//     Non-R-type func7_5 is kept only when func3=3'b101 (SRAI) and forced 0 otherwise (ADDI never SUB).
//   - Forwarding per operand, on the registered rs addr:
//     EX/MEM match (REG_WRITE & rd==rs & rd!=0) wins.
//     Else MEM/WB match (same condition) wins.
//     Else the registered RF value is used. x0 is never forwarded.
//   - ALU_DATA1 = OP1_SEL ? EX_PC : fwd_rs1.
//   - ALU_DATA2 = OP2_SEL ? imm : fwd_rs2.
//   - EX_STORE_DATA = fwd_rs2 always.
//   - Stall refresh: while STALL (no FLUSH), a held rs value is overwritten with MEMWB_RESULT when
//     MEMWB_REG_WRITE, MEMWB_RD_ADDR matches, and the rd is nonzero. Prevents stale data once the
//     producer retires during the stall. Both rs1 and rs2 refresh in the same cycle when both match.
//   - RESET mid-stall discards the held instruction.
// STRUCTURE
//   - rv32_pkg: ALU SELECT localparams (ADD=5'b00000 ... REMU=5'b11110), OP1/OP2 select encodings, XLEN.
//   - Sub-module fwd_mux: rs addr, RF data, 2 forward sources -> value. Two instances (rs1, rs2).
//   - ID/EX register and SELECT build live in this module.
// TESTING
//   - Reset: RESET=1 with ID_VALID=1 -> all outputs 0 next cycle, EX_VALID=0.
//   - SUB vs ADDI:
//     R-type func3=000, f7_5=1 -> ALU_SELECT=5'b00001.
//     I-type func3=000, f7_5=1 -> 5'b00000.
//     SRAI func3=101, f7_5=1 -> 5'b10101.
//   - Forward priority: rs1=5, EXMEM rd=5 result=0xAAAA0000, MEMWB rd=5 result=0x1234 -> ALU_DATA1=0xAAAA0000.
//     Drop EXMEM_REG_WRITE -> ALU_DATA1=0x1234.
//   - x0: rs2=0, EXMEM rd=0 REG_WRITE=1 result=0xFFFFFFFF -> ALU_DATA2 = RF value 0.
//   - Stall refresh: hold 2 cycles with rs1=7 RF=0x1. MEMWB writes rd=7 0x99 in cycle 1, then goes idle.
//     Required: ALU_DATA1=0x99 after the stall ends.
//   - FLUSH+STALL together -> EX_VALID=0, EX_REG_WRITE=0 next cycle.
//     Next unstalled load of MUL (func3=000, f7_0=1) -> SELECT=5'b00010.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32IM definitions: datapath widths, ALU SELECT codes, operand
// select encodings and the helper that builds the ALU SELECT code.
package rv32_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    // Operand source selects
    localparam logic OP1_RS1 = 1'b0;
    localparam logic OP1_PC  = 1'b1;
    localparam logic OP2_RS2 = 1'b0;
    localparam logic OP2_IMM = 1'b1;

    // func3 of the shift-right group (SRL/SRA/SRLI/SRAI)
    localparam logic [2:0] F3_SR = 3'b101;

    // ALU SELECT codes, laid out as {func3, func7[0], func7[5]}
    localparam logic [4:0] ALU_ADD    = 5'b00000;
    localparam logic [4:0] ALU_SUB    = 5'b00001;
    localparam logic [4:0] ALU_SLL    = 5'b00100;
    localparam logic [4:0] ALU_SLT    = 5'b01000;
    localparam logic [4:0] ALU_SLTU   = 5'b01100;
    localparam logic [4:0] ALU_XOR    = 5'b10000;
    localparam logic [4:0] ALU_SRL    = 5'b10100;
    localparam logic [4:0] ALU_SRA    = 5'b10101;
    localparam logic [4:0] ALU_OR     = 5'b11000;
    localparam logic [4:0] ALU_AND    = 5'b11100;
    localparam logic [4:0] ALU_MUL    = 5'b00010;
    localparam logic [4:0] ALU_MULH   = 5'b00110;
    localparam logic [4:0] ALU_MULHSU = 5'b01010;
    localparam logic [4:0] ALU_MULHU  = 5'b01110;
    localparam logic [4:0] ALU_DIV    = 5'b10010;
    localparam logic [4:0] ALU_DIVU   = 5'b10110;
    localparam logic [4:0] ALU_REM    = 5'b11010;
    localparam logic [4:0] ALU_REMU   = 5'b11110;

    // Build the ALU SELECT code. Immediate forms carry no func7, so
    // func7[0] is dropped for them; func7[5] survives only for SRAI, where
    // it is part of the immediate encoding. ADDI must never become SUB.
    function automatic logic [4:0] build_alu_select(
        input logic [2:0] func3,
        input logic       func7_0,
        input logic       func7_5,
        input logic       is_rtype
    );
        logic f7_0_eff;
        logic f7_5_eff;
        f7_0_eff = is_rtype & func7_0;
        f7_5_eff = func7_5 & (is_rtype | (func3 == F3_SR));
        return {func3, f7_0_eff, f7_5_eff};
    endfunction

endpackage

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// Forwarding mux for one source operand. EX/MEM is the younger producer
// and wins over MEM/WB; x0 is hard-wired zero and is never forwarded.
module fwd_mux #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] i_rs_addr,
    input  logic [DATA_W-1:0] i_rf_data,
    input  logic [ADDR_W-1:0] i_exmem_rd,
    input  logic              i_exmem_we,
    input  logic [DATA_W-1:0] i_exmem_result,
    input  logic [ADDR_W-1:0] i_memwb_rd,
    input  logic              i_memwb_we,
    input  logic [DATA_W-1:0] i_memwb_result,
    output logic [DATA_W-1:0] o_value
);

    logic w_rs_nonzero;
    logic w_hit_exmem;
    logic w_hit_memwb;

    assign w_rs_nonzero = (i_rs_addr != '0);
    assign w_hit_exmem  = i_exmem_we & w_rs_nonzero & (i_exmem_rd == i_rs_addr);
    assign w_hit_memwb  = i_memwb_we & w_rs_nonzero & (i_memwb_rd == i_rs_addr);

    // Pick the youngest matching producer, else the registered RF value
    always_comb begin
        o_value = i_rf_data;
        if (w_hit_exmem) begin
            o_value = i_exmem_result;
        end else if (w_hit_memwb) begin
            o_value = i_memwb_result;
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding. Holds the
// decoded instruction for one cycle, builds the ALU SELECT code at capture
// time and resolves RAW hazards against EX/MEM and MEM/WB combinationally.
module id_ex_operand_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              STALL,
    input  logic              FLUSH,
    input  logic              ID_VALID,
    input  logic [XLEN-1:0]   ID_PC,
    input  logic [XLEN-1:0]   ID_RS1_DATA,
    input  logic [XLEN-1:0]   ID_RS2_DATA,
    input  logic [XLEN-1:0]   ID_IMM,
    input  logic [REG_AW-1:0] ID_RS1_ADDR,
    input  logic [REG_AW-1:0] ID_RS2_ADDR,
    input  logic [REG_AW-1:0] ID_RD_ADDR,
    input  logic [2:0]        ID_FUNC3,
    input  logic              ID_FUNC7_0,
    input  logic              ID_FUNC7_5,
    input  logic              ID_IS_RTYPE,
    input  logic              ID_OP1_SEL,
    input  logic              ID_OP2_SEL,
    input  logic              ID_REG_WRITE,
    input  logic [REG_AW-1:0] EXMEM_RD_ADDR,
    input  logic              EXMEM_REG_WRITE,
    input  logic [XLEN-1:0]   EXMEM_RESULT,
    input  logic [REG_AW-1:0] MEMWB_RD_ADDR,
    input  logic              MEMWB_REG_WRITE,
    input  logic [XLEN-1:0]   MEMWB_RESULT,
    output logic [XLEN-1:0]   ALU_DATA1,
    output logic [XLEN-1:0]   ALU_DATA2,
    output logic [4:0]        ALU_SELECT,
    output logic [XLEN-1:0]   EX_STORE_DATA,
    output logic [XLEN-1:0]   EX_PC,
    output logic [REG_AW-1:0] EX_RD_ADDR,
    output logic              EX_REG_WRITE,
    output logic              EX_VALID
);

    import rv32_pkg::*;

    // ID/EX register contents
    logic              r_valid;
    logic              r_reg_write;
    logic [4:0]        r_select;
    logic [REG_AW-1:0] r_rd_addr;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_imm;
    logic              r_op1_sel;
    logic              r_op2_sel;
    logic [REG_AW-1:0] r_rs_addr [2];
    logic [XLEN-1:0]   r_rs_data [2];

    logic [XLEN-1:0]   w_fwd     [2];
    logic              w_refresh [2];
    logic [4:0]        w_select;

    assign w_select = build_alu_select(ID_FUNC3, ID_FUNC7_0, ID_FUNC7_5, ID_IS_RTYPE);

    // Per-operand forwarding and stall-refresh detection
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_operand
            // A held operand whose producer retires from MEM/WB during a
            // stall would otherwise be lost once MEM/WB moves on.
            assign w_refresh[gi] = MEMWB_REG_WRITE
                                 & (MEMWB_RD_ADDR == r_rs_addr[gi])
                                 & (r_rs_addr[gi] != '0);

            fwd_mux #(
                .DATA_W (XLEN),
                .ADDR_W (REG_AW)
            ) u_fwd_mux (
                .i_rs_addr      (r_rs_addr[gi]),
                .i_rf_data      (r_rs_data[gi]),
                .i_exmem_rd     (EXMEM_RD_ADDR),
                .i_exmem_we     (EXMEM_REG_WRITE),
                .i_exmem_result (EXMEM_RESULT),
                .i_memwb_rd     (MEMWB_RD_ADDR),
                .i_memwb_we     (MEMWB_REG_WRITE),
                .i_memwb_result (MEMWB_RESULT),
                .o_value        (w_fwd[gi])
            );
        end
    endgenerate

    // ID/EX register: reset > flush > stall (with refresh) > load; invalid loads become bubbles
    always_ff @(posedge CLK) begin
        if (RESET || FLUSH || (!STALL && !ID_VALID)) begin
            r_valid      <= 1'b0;
            r_reg_write  <= 1'b0;
            r_select     <= ALU_ADD;
            r_rd_addr    <= '0;
            r_pc         <= '0;
            r_imm        <= '0;
            r_op1_sel    <= OP1_RS1;
            r_op2_sel    <= OP2_RS2;
            r_rs_addr[0] <= '0;
            r_rs_addr[1] <= '0;
            r_rs_data[0] <= '0;
            r_rs_data[1] <= '0;
        end else if (STALL) begin
            for (int i = 0; i < 2; i++) begin
                if (w_refresh[i]) begin
                    r_rs_data[i] <= MEMWB_RESULT;
                end
            end
        end else begin
            r_valid      <= 1'b1;
            r_reg_write  <= ID_REG_WRITE;
            r_select     <= w_select;
            r_rd_addr    <= ID_RD_ADDR;
            r_pc         <= ID_PC;
            r_imm        <= ID_IMM;
            r_op1_sel    <= ID_OP1_SEL;
            r_op2_sel    <= ID_OP2_SEL;
            r_rs_addr[0] <= ID_RS1_ADDR;
            r_rs_addr[1] <= ID_RS2_ADDR;
            r_rs_data[0] <= ID_RS1_DATA;
            r_rs_data[1] <= ID_RS2_DATA;
        end
    end

    // ALU operand muxes after forwarding
    always_comb begin
        ALU_DATA1 = w_fwd[0];
        ALU_DATA2 = w_fwd[1];
        if (r_op1_sel == OP1_PC) begin
            ALU_DATA1 = r_pc;
        end
        if (r_op2_sel == OP2_IMM) begin
            ALU_DATA2 = r_imm;
        end
    end

    assign ALU_SELECT    = r_select;
    assign EX_STORE_DATA = w_fwd[1];
    assign EX_PC         = r_pc;
    assign EX_RD_ADDR    = r_rd_addr;
    assign EX_REG_WRITE  = r_reg_write;
    assign EX_VALID      = r_valid;

endmodule
